sobel_window_ctrl: RTL and testbench
====================================

Name: sobel_window_ctrl

Overview:
Streaming controller that sequences the Sobel operator datapath. It accepts a raster-order 8-bit pixel stream and keeps two line buffers and a 3x3 window. It drives the 72-bit window into the registered Sobel operator and tracks operator latency. Results go into an output FIFO with valid/ready backpressure, and the block signals end of frame.

Parameters:
- IMG_W, 16, pixels per line (>=3)
- IMG_H, 16, lines per frame (>=3)
- OFIFO_DEPTH, 4, output FIFO entries (power of 2, >=4)

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  controller accepts pixel
- in_data  in  8  pixel, unsigned
- win_data  out  72  window to Sobel operator
- op_out  in  8  registered Sobel result (1-cycle latency from win_data)
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  8  result
- out_last  out  1  marks final result of frame
- frame_done  out  1  one-cycle pulse when frame fully drained

Behaviour:
- Reset: in_ready=0, out_valid=0, out_data=0, out_last=0, frame_done=0, win_data=0. Counters, pipeline flags and FIFO are cleared. State=FILL. Line buffer contents are don't-care.
- Window layout is column-major: win_data[(c*3+r)*8 +: 8] = pixel at window row r, column c.
  - r=0 is the oldest line (two lines up); r=2 is the current line.
  - c=0 is the oldest column; c=2 is the current pixel.
- Accept occurs when in_valid && in_ready.
  - On accept, each window row shifts left by one column.
  - Column 2 loads {linebuf1[col], linebuf0[col], in_data}.
  - linebuf1[col] <= linebuf0[col]; linebuf0[col] <= in_data.
  - col increments. It wraps at IMG_W-1 to 0 and row increments.
- Pipeline flags:
  - wv <= accept && row>=2 && col>=2.
  - ov <= wv on every cycle.
  - When ov=1, op_out is pushed into the FIFO.
  - Total latency from accepting the pixel at (row,col) to the FIFO push of the result centred at (row-1,col-1) is 2 cycles.
- Only interior pixels are emitted: (IMG_W-2)*(IMG_H-2) results per frame. Borders are dropped; there is no row wrap artefact because col>=2 gates emission.
- Credit rule: in_ready = (state!=DRAIN) && (fifo_count + wv + ov <= OFIFO_DEPTH-1). The FIFO therefore never overflows. The operator register is free-running and is never stalled.
- FIFO behaviour:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - A pop occurs on out_valid && out_ready.
  - A simultaneous push and pop leaves the count unchanged.
- States:
  - FILL (row<2) -> RUN on accepting the last pixel of row 1.
  - RUN -> DRAIN on accepting pixel (IMG_H-1, IMG_W-1).
  - DRAIN holds in_ready=0 until wv=0, ov=0 and the FIFO is empty. It then pulses frame_done, clears row/col and returns to FILL.
- out_last=1 while the FIFO head is the final result of the frame. This is tracked by a per-entry tag bit.
- Reset mid-frame discards all in-flight data and restarts at pixel (0,0). No frame_done is issued.

Optional Feature:
- Macro: SOBEL_CTRL_STALL_CNT_EN.
- When defined, the block adds output port stall_cycles [31:0].
  - It counts cycles with in_valid && !in_ready and saturates at 0xFFFFFFFF.
  - It clears to 0 on reset and on the cycle frame_done pulses.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package sobel_pkg holds:
  - PIX_W=8 and WIN_PIX=9.
  - Window index function win_idx(r,c)=c*3+r.
  - State encoding FILL/RUN/DRAIN.
- Sub-module sobel_ofifo: synchronous FIFO with parameter DEPTH. Payload is {last, data[7:0]}; outputs count, empty and full.
- Line buffers are inferred inline as two IMG_W x 8 arrays.

Test Plan:
All scenarios use IMG_W=8, IMG_H=6, paired with the Sobel operator.
- Flat frame, all pixels 50, out_ready=1 -> exactly 24 results, all 0; out_last on the 24th; frame_done 1 cycle after the last pop.
- Vertical edge, cols 0-3=0 and cols 4-7=100 -> each interior row gives results 0,0,200,200,0,0 (centre cols 1..6).
- Backpressure: out_ready toggles 1 cycle on / 3 off with in_valid=1 constantly -> same 24 values in order, no loss or duplication; fifo_count never exceeds 4.
- Frame boundary: two frames back-to-back -> in_ready=0 during DRAIN, and the second frame's results are identical to the standalone run.
- Reset asserted mid-row 3 -> outputs go to reset values immediately; a fresh full frame afterwards gives the correct 24 results.
- With SOBEL_CTRL_STALL_CNT_EN defined and out_ready=0 for 10 cycles mid-frame -> stall_cycles equals the counted in_valid&&!in_ready cycles, then clears on frame_done.

Source files
------------

// File: rtl/sobel_window_ctrl_pkg.sv
// Shared types for the Sobel window controller: pixel/window geometry,
// controller state encoding and the output FIFO entry layout.
package sobel_pkg;
  localparam int PIX_W   = 8;
  localparam int WIN_PIX = 9;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic             last;
    logic [PIX_W-1:0] data;
  } ofifo_entry_t;

  // Column-major slot of window pixel (row r, column c); row 0 is the oldest line.
  function automatic logic [3:0] win_idx(input int r, input int c);
    return 4'(c * 3 + r);
  endfunction
endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-in / window-out / result-out bundle of the Sobel window controller.
// slave is the controller side, master the source/operator/sink side.
interface sobel_window_ctrl_if;
  import sobel_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [PIX_W-1:0]         in_data;
  logic [WIN_PIX*PIX_W-1:0] win_data;
  logic [PIX_W-1:0]         op_out;
  logic                     out_valid;
  logic                     out_ready;
  logic [PIX_W-1:0]         out_data;
  logic                     out_last;
  logic                     frame_done;

  modport slave (
    input  in_valid, in_data, op_out, out_ready,
    output in_ready, win_data, out_valid, out_data, out_last, frame_done
  );

  modport master (
    output in_valid, in_data, op_out, out_ready,
    input  in_ready, win_data, out_valid, out_data, out_last, frame_done
  );
endinterface

// File: rtl/sobel_window_ctrl_ofifo.sv
// Output result FIFO: {last, data} entries, power-of-two DEPTH, registered
// pointers and occupancy count.
module sobel_ofifo
  import sobel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  ofifo_entry_t           i_din,
  input  logic                   i_pop,
  output ofifo_entry_t           o_dout,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  ofifo_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [NW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == NW'(DEPTH));
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sobel_window_ctrl.sv
// Sobel window controller: line buffers + 3x3 window feeding an external
// registered operator, credit-based output FIFO and end-of-frame drain.
// Optional stall counter port enabled by SOBEL_CTRL_STALL_CNT_EN.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W       = 16,
  parameter int IMG_H       = 16,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  sobel_window_ctrl_if.slave  bus
`ifdef SOBEL_CTRL_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = $clog2(OFIFO_DEPTH) + 1;
  localparam int IW = FW + 1;

  state_e                          r_state;
  state_e                          w_state_nxt;
  logic [CW-1:0]                   r_col;
  logic [RW-1:0]                   r_row;
  logic [WIN_PIX-1:0][PIX_W-1:0]   r_win;
  logic [PIX_W-1:0]                r_lb0 [IMG_W];
  logic [PIX_W-1:0]                r_lb1 [IMG_W];
  logic                            r_wv;
  logic                            r_ov;
  logic                            r_wl;
  logic                            r_ol;
  logic                            r_armed;

  logic                            w_in_ready;
  logic                            w_accept;
  logic                            w_last_col;
  logic                            w_last_pix;
  logic                            w_frame_done;
  logic                            w_credit;
  logic [IW-1:0]                   w_inflight;
  logic [FW-1:0]                   w_fifo_count;
  logic                            w_fifo_empty;
  logic                            w_fifo_full;
  logic                            w_pop;
  ofifo_entry_t                    w_push_data;
  ofifo_entry_t                    w_head;

  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_last_col = (r_col == CW'(IMG_W - 1));
  assign w_last_pix = w_last_col && (r_row == RW'(IMG_H - 1));

  // Everything already committed to the FIFO (queued, in the operator, or
  // in the window stage) must leave room for the pixel being accepted now.
  assign w_inflight = IW'(w_fifo_count) + IW'(r_wv) + IW'(r_ov);
  assign w_credit   = !w_fifo_full && (w_inflight <= IW'(OFIFO_DEPTH - 1));
  assign w_in_ready = r_armed && (r_state != DRAIN) && w_credit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept && (r_row == RW'(1)) && w_last_col) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_accept && w_last_pix) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_wv && !r_ov && w_fifo_empty) begin
          w_frame_done = 1'b1;
          w_state_nxt  = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col   <= '0;
      r_row   <= '0;
      r_win   <= '0;
      r_wv    <= 1'b0;
      r_ov    <= 1'b0;
      r_wl    <= 1'b0;
      r_ol    <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      // col>=2 keeps the window from straddling the previous row's tail.
      r_wv    <= w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
      r_wl    <= w_accept && w_last_pix;
      r_ov    <= r_wv;
      r_ol    <= r_wl;
      if (w_frame_done) begin
        r_col <= '0;
        r_row <= '0;
      end else if (w_accept) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_accept) begin
        for (int r = 0; r < 3; r++) begin
          r_win[win_idx(r, 0)] <= r_win[win_idx(r, 1)];
          r_win[win_idx(r, 1)] <= r_win[win_idx(r, 2)];
        end
        r_win[win_idx(0, 2)] <= r_lb1[r_col];
        r_win[win_idx(1, 2)] <= r_lb0[r_col];
        r_win[win_idx(2, 2)] <= bus.in_data;
      end
    end
  end

  // Line buffer contents need no reset: rows 0/1 of a frame never emit.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= bus.in_data;
    end
  end

  assign w_push_data = {r_ol, bus.op_out};
  assign w_pop       = !w_fifo_empty && bus.out_ready;

  sobel_ofifo #(.DEPTH(OFIFO_DEPTH)) u_ofifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (r_ov),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.win_data   = r_win;
  assign bus.out_valid  = !w_fifo_empty;
  assign bus.out_data   = w_fifo_empty ? '0 : w_head.data;
  assign bus.out_last   = !w_fifo_empty && w_head.last;
  assign bus.frame_done = w_frame_done;

`ifdef SOBEL_CTRL_STALL_CNT_EN
  logic [31:0] r_stall;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                        r_stall <= '0;
    else if (w_frame_done)                            r_stall <= '0;
    else if (bus.in_valid && !w_in_ready && r_stall != '1) r_stall <= r_stall + 1'b1;
  end

  assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Scoreboard bench for sobel_window_ctrl with a behavioural registered Sobel
// operator; expected results are hand-derived per directed image pattern.
module tb_sobel_window_ctrl;
  localparam int W   = 8;
  localparam int H   = 6;
  localparam int D   = 4;
  localparam int TMO = 2000;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sobel_window_ctrl_if sif();
`ifdef SOBEL_CTRL_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .OFIFO_DEPTH(D)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
`ifdef SOBEL_CTRL_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int         checks = 0;
  int         failures = 0;
  logic [8:0] sb [$];
  bit         sb_ignore = 1'b0;
  int         or_mode = 0;
  int         cyc = 0;
  int         last_pop_cyc = -100;
  int         n_done = 0;
  int         max_cnt = 0;
  int         tb_stalls = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic abort(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout", nm);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  // |Gx|+|Gy| halved and saturated; window is column-major, row 0 oldest.
  function automatic logic [7:0] sobel_op(input logic [71:0] w);
    int p [3][3];
    int gx, gy, s;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'(w[(c*3+r)*8 +: 8]);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = (gx + gy) / 2;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  always @(posedge clock) sif.op_out <= sobel_op(sif.win_data);

  // 0: flat 50; 1: vertical edge at col 4; 2: horizontal edge at row 3.
  function automatic logic [7:0] pix(input int pat, input int r, input int c);
    case (pat)
      1:       return (c < 4) ? 8'd0 : 8'd100;
      2:       return (r < 3) ? 8'd0 : 8'd100;
      default: return 8'd50;
    endcase
  endfunction

  function automatic logic [7:0] exp_val(input int pat, input int r, input int c);
    case (pat)
      1:       return (c == 3 || c == 4) ? 8'd200 : 8'd0;
      2:       return (r == 2 || r == 3) ? 8'd200 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  task automatic push_frame(input int pat);
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++)
        sb.push_back({(r == H - 2 && c == W - 2), exp_val(pat, r, c)});
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_pix(input logic [7:0] p);
    int n = 0;
    sif.in_valid = 1'b1;
    sif.in_data  = p;
    while (!sif.in_ready && n < TMO) begin
      tb_stalls++;
      n++;
      @(negedge clock);
    end
    if (n >= TMO) abort("send_pix");
    @(negedge clock);
  endtask

  task automatic run_frame(input int pat, input bit keep_valid);
    push_frame(pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(pix(pat, r, c));
    if (!keep_valid) sif.in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit chk_drain);
    int n = 0;
    while (!sif.frame_done && n < TMO) begin
      if (chk_drain) chk("drain_in_ready", sif.in_ready, 0);
      n++;
      @(negedge clock);
    end
    if (n >= TMO) abort("wait_done");
    if (chk_drain) chk("done_in_ready", sif.in_ready, 0);
    @(negedge clock);
  endtask

  initial begin
    int ph = 0;
    sif.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (or_mode)
        1: begin
          sif.out_ready = (ph == 0);
          ph = (ph + 1) % 4;
        end
        2:       sif.out_ready = 1'b0;
        default: sif.out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        if (sif.out_valid && sif.out_ready && !sb_ignore) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%0h required=none", {sif.out_last, sif.out_data});
          end else begin
            e = sb.pop_front();
            chk("res_data", sif.out_data, e[7:0]);
            chk("res_last", sif.out_last, e[8]);
            if (sif.out_last) last_pop_cyc = cyc;
          end
        end
        if (sif.frame_done) begin
          n_done++;
          chk("done_after_last_pop", cyc - last_pop_cyc, 1);
        end
        if (int'(dut.u_ofifo.o_count) > max_cnt) max_cnt = int'(dut.u_ofifo.o_count);
      end
    end
  end

  initial begin
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    reset        = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_in_ready",   sif.in_ready,   0);
    chk("rst_out_valid",  sif.out_valid,  0);
    chk("rst_out_data",   sif.out_data,   0);
    chk("rst_out_last",   sif.out_last,   0);
    chk("rst_frame_done", sif.frame_done, 0);
    chk("rst_win_data",   sif.win_data,   0);
    reset = 1'b0;
    @(negedge clock);

    or_mode = 0;
    run_frame(0, 1'b0);
    wait_done(1'b0);

    run_frame(1, 1'b0);
    wait_done(1'b0);

    or_mode = 1;
    run_frame(1, 1'b0);
    wait_done(1'b0);
    chk("fifo_max_le_depth", (max_cnt <= D), 1);
    or_mode = 0;

    run_frame(2, 1'b1);
    wait_done(1'b1);
    run_frame(2, 1'b0);
    wait_done(1'b0);

    // Abandon a frame partway through row 3.
    sb_ignore = 1'b1;
    for (int i = 0; i < 3*W + 4; i++) send_pix(pix(1, i / W, i % W));
    sif.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_in_ready",   sif.in_ready,   0);
    chk("mid_rst_out_valid",  sif.out_valid,  0);
    chk("mid_rst_out_data",   sif.out_data,   0);
    chk("mid_rst_out_last",   sif.out_last,   0);
    chk("mid_rst_frame_done", sif.frame_done, 0);
    chk("mid_rst_win_data",   sif.win_data,   0);
    @(negedge clock);
    reset = 1'b0;
    sb_ignore = 1'b0;
    @(negedge clock);
    run_frame(1, 1'b0);
    wait_done(1'b0);

    // Ten cycles of blocked output mid-frame.
    tb_stalls = 0;
    fork
      begin
        repeat (30) @(negedge clock);
        or_mode = 2;
        repeat (10) @(negedge clock);
        or_mode = 0;
      end
    join_none
    run_frame(0, 1'b0);
`ifdef SOBEL_CTRL_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, tb_stalls);
`endif
    wait_done(1'b0);
`ifdef SOBEL_CTRL_STALL_CNT_EN
    chk("stall_cleared", stall_cycles, 0);
`endif

    repeat (5) @(negedge clock);
    chk("sb_drained", sb.size(), 0);
    chk("frames_done", n_done, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
